hazard_detection_unit_r1: RTL and testbench

- Parametrised successor to the r0 load-use detector for the 5-stage MIPS pipeline; sits in ID beside the register file and drives PC / IF-ID write enables and the ID/EX bubble.
- Adds:
  - multi-cycle load-use stalls (configurable memory latency);
  - ID-stage branch operand hazards;
  - multi-cycle MDU busy interlock;
  - taken-branch IF/ID flush.
- Hazard detection is combinational in the first cycle; a small FSM sustains multi-cycle stalls.

---
 rtl/hazard_detection_unit_r1.sv | 128 ++++++++++++
 tb/tb_hazard_detection_unit_r1.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_detection_unit_r1.sv
// rtl/hazard_detection_unit_r1.sv - ID-stage hazard detector with multi-cycle load/MDU stalls and branch flush
// Optional saturating stall counter output enabled by HDU_STALL_COUNT_EN.
module hazard_detection_unit_r1 #(
   parameter int BIT_WIDTH         = 32,
   parameter int REG_ADDR_WIDTH    = 5,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int DELAY             = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_ADDR_WIDTH-1:0] rs,
   input  logic [REG_ADDR_WIDTH-1:0] rt,
   input  logic                      id_uses_rs,
   input  logic                      id_uses_rt,
   input  logic                      id_is_branch,
   input  logic                      id_uses_mdu,
   input  logic                      ex_memRead,
   input  logic                      ex_regWrite,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
   input  logic                      mem_memRead,
   input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
   input  logic                      mdu_busy,
   input  logic                      branch_taken,
   output logic                      PC_write,
   output logic                      IDIF_write,
   output logic                      IDIF_flush,
   output logic                      ex_noop,
   output logic                      stall_active
`ifdef HDU_STALL_COUNT_EN
   ,
   output logic [BIT_WIDTH-1:0]      stall_count
`endif
);

   typedef enum logic [1:0] {RUN, LOAD_WAIT, MDU_WAIT} state_t;

   localparam logic [3:0] LOAD_RELOAD = 4'(LOAD_STALL_CYCLES - 1);

   // Elaboration-time sanity anchor; DELAY has no functional effect.
   if (DELAY < 0 || BIT_WIDTH < 1 || LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 15) begin : g_bad_cfg
   end

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       rs_ex, rt_ex, rs_mem, rt_mem;
   logic       hz_lu, hz_br, hz_md;
   logic       stall;

   assign rs_ex  = id_uses_rs & (rs == ex_rd)  & (rs != '0);
   assign rt_ex  = id_uses_rt & (rt == ex_rd)  & (rt != '0);
   assign rs_mem = id_uses_rs & (rs == mem_rd) & (rs != '0);
   assign rt_mem = id_uses_rt & (rt == mem_rd) & (rt != '0);

   assign hz_lu = ex_memRead & (rs_ex | rt_ex);
   assign hz_br = id_is_branch & ((ex_regWrite & (rs_ex | rt_ex)) | (mem_memRead & (rs_mem | rt_mem)));
   assign hz_md = id_uses_mdu & mdu_busy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         RUN: begin
            cnt_nxt = '0;
            if (hz_lu) begin
               if (LOAD_STALL_CYCLES > 1) begin
                  state_nxt = LOAD_WAIT;
                  cnt_nxt   = LOAD_RELOAD;
               end
            end else if (hz_md) begin
               state_nxt = MDU_WAIT;
            end
         end
         LOAD_WAIT: begin
            if (cnt <= 4'd1) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         MDU_WAIT: begin
            if (!mdu_busy) state_nxt = RUN;
         end
         default: begin
            state_nxt = RUN;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are held at their idle values while reset is asserted.
   always_comb begin
      stall = 1'b0;
      case (state)
         RUN:       stall = hz_lu | hz_br | hz_md;
         LOAD_WAIT: stall = 1'b1;
         MDU_WAIT:  stall = mdu_busy;
         default:   stall = 1'b0;
      endcase
      if (!rst) stall = 1'b0;
      stall_active = stall;
      PC_write     = ~stall;
      IDIF_write   = ~stall;
      ex_noop      = stall;
      IDIF_flush   = rst & branch_taken & ~stall;
   end

`ifdef HDU_STALL_COUNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_count <= '0;
      end else if (stall_active && (stall_count != '1)) begin
         stall_count <= stall_count + BIT_WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_hazard_detection_unit_r1.sv
// tb/tb_hazard_detection_unit_r1.sv - directed bench for hazard_detection_unit_r1 at LOAD_STALL_CYCLES 1/3/5
module tb_hazard_detection_unit_r1;

   logic       clk;
   logic       rst;
   logic [4:0] rs, rt, ex_rd, mem_rd;
   logic       id_uses_rs, id_uses_rt, id_is_branch, id_uses_mdu;
   logic       ex_memRead, ex_regWrite, mem_memRead, mdu_busy, branch_taken;

   logic pcw1, ifw1, fl1, nop1, st1;
   logic pcw3, ifw3, fl3, nop3, st3;
   logic pcw5, ifw5, fl5, nop5, st5;
`ifdef HDU_STALL_COUNT_EN
   logic [31:0] sc1, sc3, sc5;
`endif

   int total = 0;
   int bad   = 0;

   hazard_detection_unit_r1 #(.LOAD_STALL_CYCLES(1)) u1 (
      .clk(clk), .rst(rst), .rs(rs), .rt(rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_is_branch(id_is_branch), .id_uses_mdu(id_uses_mdu), .ex_memRead(ex_memRead),
      .ex_regWrite(ex_regWrite), .ex_rd(ex_rd), .mem_memRead(mem_memRead), .mem_rd(mem_rd),
      .mdu_busy(mdu_busy), .branch_taken(branch_taken), .PC_write(pcw1), .IDIF_write(ifw1),
      .IDIF_flush(fl1), .ex_noop(nop1), .stall_active(st1)
`ifdef HDU_STALL_COUNT_EN
      , .stall_count(sc1)
`endif
   );

   hazard_detection_unit_r1 #(.LOAD_STALL_CYCLES(3)) u3 (
      .clk(clk), .rst(rst), .rs(rs), .rt(rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_is_branch(id_is_branch), .id_uses_mdu(id_uses_mdu), .ex_memRead(ex_memRead),
      .ex_regWrite(ex_regWrite), .ex_rd(ex_rd), .mem_memRead(mem_memRead), .mem_rd(mem_rd),
      .mdu_busy(mdu_busy), .branch_taken(branch_taken), .PC_write(pcw3), .IDIF_write(ifw3),
      .IDIF_flush(fl3), .ex_noop(nop3), .stall_active(st3)
`ifdef HDU_STALL_COUNT_EN
      , .stall_count(sc3)
`endif
   );

   hazard_detection_unit_r1 #(.LOAD_STALL_CYCLES(5)) u5 (
      .clk(clk), .rst(rst), .rs(rs), .rt(rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_is_branch(id_is_branch), .id_uses_mdu(id_uses_mdu), .ex_memRead(ex_memRead),
      .ex_regWrite(ex_regWrite), .ex_rd(ex_rd), .mem_memRead(mem_memRead), .mem_rd(mem_rd),
      .mdu_busy(mdu_busy), .branch_taken(branch_taken), .PC_write(pcw5), .IDIF_write(ifw5),
      .IDIF_flush(fl5), .ex_noop(nop5), .stall_active(st5)
`ifdef HDU_STALL_COUNT_EN
      , .stall_count(sc5)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic clr;
      rs = '0; rt = '0; ex_rd = '0; mem_rd = '0;
      id_uses_rs = 0; id_uses_rt = 0; id_is_branch = 0; id_uses_mdu = 0;
      ex_memRead = 0; ex_regWrite = 0; mem_memRead = 0; mdu_busy = 0; branch_taken = 0;
   endtask

   task automatic set_lu;
      ex_memRead = 1; ex_rd = 5'd5; rs = 5'd5; id_uses_rs = 1;
   endtask

   initial begin
      rst = 0;
      clr();
      set_lu();
      branch_taken = 1;
      #2;
      chk("rst_pcw", pcw1, 1);
      chk("rst_ifw", ifw1, 1);
      chk("rst_nop", nop1, 0);
      chk("rst_flush", fl1, 0);
      chk("rst_stall", st1, 0);
      chk("rst_stall5", st5, 0);
      cyc();
      rst = 1;
      clr();
      #1;
      chk("idle_stall", st1, 0);
`ifdef HDU_STALL_COUNT_EN
      chk("cnt_after_rst", sc5, 0);
`endif

      // Load-use: hazard only in the first cycle, bubbles sustained by LOAD_WAIT
      cyc();
      set_lu();
      branch_taken = 1;
      #1;
      chk("lu1_pcw", pcw1, 0);
      chk("lu1_ifw", ifw1, 0);
      chk("lu1_nop", nop1, 1);
      chk("lu1_stall", st1, 1);
      chk("lu1_flush_ignored", fl1, 0);
      chk("lu3_c1", st3, 1);
      chk("lu5_c1", st5, 1);
      for (int k = 2; k <= 6; k++) begin
         cyc();
         clr();
         #1;
         chk($sformatf("lu1_c%0d", k), st1, 0);
         chk($sformatf("lu3_c%0d", k), st3, (k <= 3) ? 1 : 0);
         chk($sformatf("lu5_c%0d", k), st5, (k <= 5) ? 1 : 0);
         if (k == 4) chk("lu3_pcw_release", pcw3, 1);
      end
`ifdef HDU_STALL_COUNT_EN
      chk("cnt3", sc3, 3);
      chk("cnt5", sc5, 5);
`endif

      // Register-0 and unqualified-operand cases
      cyc();
      clr();
      ex_memRead = 1; ex_rd = 0; rs = 0; id_uses_rs = 1;
      #1;
      chk("r0_nostall", st1, 0);
      chk("r0_pcw", pcw1, 1);
      ex_rd = 5'd5; rs = 5'd3;
      #1;
      chk("nomatch_nostall", st1, 0);
      clr();
      ex_memRead = 1; rt = 5'd7; ex_rd = 5'd7; id_uses_rt = 0;
      #1;
      chk("rt_unused_nostall", st1, 0);
      id_uses_rt = 1;
      #1;
      chk("rt_used_stall", st1, 1);
      cyc();
      clr();
      repeat (6) cyc();

      // Branch operand hazard, flush suppression, then flush
      clr();
      id_is_branch = 1; rt = 5'd9; id_uses_rt = 1; mem_memRead = 1; mem_rd = 5'd9; branch_taken = 1;
      #1;
      chk("br_mem_stall", st1, 1);
      chk("br_mem_flush", fl1, 0);
      chk("br_mem_pcw", pcw1, 0);
      cyc();
      clr();
      branch_taken = 1;
      #1;
      chk("br_flush", fl1, 1);
      chk("br_flush_pcw", pcw1, 1);
      chk("br_flush_ifw", ifw1, 1);
      chk("br_flush_u5", fl5, 1);
      cyc();
      clr();
      id_is_branch = 1; rs = 5'd9; id_uses_rs = 1; ex_regWrite = 1; ex_rd = 5'd9;
      #1;
      chk("br_ex_stall", st1, 1);
      id_is_branch = 0;
      #1;
      chk("nonbr_ex_nostall", st1, 0);
      clr();
      id_is_branch = 1; rs = 5'd9; id_uses_rs = 1; mem_rd = 5'd9;
      #1;
      chk("br_mem_noload", st1, 0);

      // MDU busy for 4 cycles
      cyc();
      clr();
      id_uses_mdu = 1; mdu_busy = 1;
      #1;
      chk("mdu_c1", st1, 1);
      for (int k = 2; k <= 4; k++) begin
         cyc();
         branch_taken = (k == 3);
         #1;
         chk($sformatf("mdu_c%0d", k), st1, 1);
         if (k == 3) chk("mdu_flush_ignored", fl1, 0);
      end
      cyc();
      branch_taken = 0;
      mdu_busy = 0;
      #1;
      chk("mdu_drop", st1, 0);
      chk("mdu_drop_pcw", pcw1, 1);
      cyc();
      #1;
      chk("mdu_after", st1, 0);

      // LU beats MD: u3 must leave LOAD_WAIT after 3 cycles despite mdu_busy
      cyc();
      clr();
      set_lu();
      id_uses_mdu = 1; mdu_busy = 1;
      #1;
      chk("prio_c1", st3, 1);
      for (int k = 2; k <= 4; k++) begin
         cyc();
         clr();
         mdu_busy = 1;
         #1;
         chk($sformatf("prio_c%0d", k), st3, (k <= 3) ? 1 : 0);
      end
      cyc();
      clr();
      repeat (5) cyc();

      // Reset in the 2nd LOAD_WAIT cycle of u5
      set_lu();
      #1;
      chk("rlw_c1", st5, 1);
      cyc();
      clr();
      #1;
      chk("rlw_c2", st5, 1);
      cyc();
      #1;
      chk("rlw_c3", st5, 1);
      branch_taken = 1;
      rst = 0;
      #1;
      chk("rlw_stall", st5, 0);
      chk("rlw_pcw", pcw5, 1);
      chk("rlw_ifw", ifw5, 1);
      chk("rlw_nop", nop5, 0);
      chk("rlw_flush", fl5, 0);
`ifdef HDU_STALL_COUNT_EN
      chk("rlw_cnt", sc5, 0);
`endif
      cyc();
      rst = 1;
      branch_taken = 0;
      #1;
      chk("rlw_rel1", st5, 0);
      cyc();
      #1;
      chk("rlw_rel2", st5, 0);
      chk("rlw_rel2_pcw", pcw5, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
